// File: rtl/crc_frame_serializer_if.sv
// crc_frame_serializer_if: load/serial handshake bundle for the CRC-9 frame serializer (crc_err ports exist only with CRC_SELFCHECK_EN)
interface crc_frame_serializer_if #(parameter int COUNT_W = 8);
    logic [9:0]         data_in;
    logic [8:0]         crc_in;
    logic               load_valid;
    logic               load_ready;
    logic               ser_ready;
    logic               ser_out;
    logic               ser_valid;
    logic               frame_start;
    logic               frame_end;
    logic               crc_phase;
    logic [COUNT_W-1:0] frame_count;
`ifdef CRC_SELFCHECK_EN
    logic               crc_err;
    logic               crc_err_sticky;
    modport master (output data_in, crc_in, load_valid, ser_ready,
                    input load_ready, ser_out, ser_valid, frame_start, frame_end, crc_phase, frame_count,
                    crc_err, crc_err_sticky);
    modport slave (input data_in, crc_in, load_valid, ser_ready,
                   output load_ready, ser_out, ser_valid, frame_start, frame_end, crc_phase, frame_count,
                   crc_err, crc_err_sticky);
`else
    modport master (output data_in, crc_in, load_valid, ser_ready,
                    input load_ready, ser_out, ser_valid, frame_start, frame_end, crc_phase, frame_count);
    modport slave (input data_in, crc_in, load_valid, ser_ready,
                   output load_ready, ser_out, ser_valid, frame_start, frame_end, crc_phase, frame_count);
`endif
endinterface

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: serializes {data, crc9} MSB first with backpressure, markers and frame counter; CRC_SELFCHECK_EN adds an LFSR re-check
module crc_frame_serializer #(
    parameter int GAP_CYCLES = 1,
    parameter int COUNT_W    = 8
) (
    input logic                    clk,
    input logic                    reset_n,
    crc_frame_serializer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             r_state;
    logic [18:0]        r_sr;
    logic [4:0]         r_idx;
    logic [3:0]         r_gap;
    logic [COUNT_W-1:0] r_count;
    logic               w_send;
    logic               w_xfer;
    logic               w_last;
    logic               w_load;

    assign w_send          = r_state == SEND;
    assign w_xfer          = w_send && bus.ser_ready;
    assign w_last          = w_xfer && r_idx == 5'd0;
    assign bus.load_ready  = (r_state == IDLE) || (GAP_CYCLES == 0 && w_last);
    assign w_load          = bus.load_valid && bus.load_ready;
    assign bus.ser_out     = r_sr[18];
    assign bus.ser_valid   = w_send;
    assign bus.frame_start = w_send && r_idx == 5'd18;
    assign bus.frame_end   = w_send && r_idx == 5'd0;
    assign bus.crc_phase   = w_send && r_idx <= 5'd8;
    assign bus.frame_count = r_count;

    // Frame FSM: load a codeword, shift it out one accepted bit at a time, then idle for the gap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_count <= '0;
        end else begin
            if (w_load) begin
                r_sr    <= {bus.data_in, bus.crc_in};
                r_idx   <= 5'd18;
                r_state <= SEND;
            end else begin
                case (r_state)
                    SEND: if (bus.ser_ready) begin
                        if (r_idx == 5'd0) begin
                            r_state <= GAP_CYCLES > 0 ? GAP : IDLE;
                        end else begin
                            r_sr  <= {r_sr[17:0], 1'b0};
                            r_idx <= r_idx - 5'd1;
                        end
                    end
                    GAP: begin
                        r_gap <= r_gap + 4'd1;
                        if (r_gap == 4'(GAP_CYCLES - 1)) begin
                            r_state <= IDLE;
                            r_gap   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_last) r_count <= r_count + 1'b1;
        end
    end

`ifdef CRC_SELFCHECK_EN
    logic [8:0] r_lfsr;
    logic       r_mis;
    logic       r_err;
    logic       r_sticky;
    logic       w_bad;

    assign w_bad              = r_sr[18] ^ r_lfsr[8];
    assign bus.crc_err        = r_err;
    assign bus.crc_err_sticky = r_sticky;

    // Re-derive the remainder from sent message bits, then compare it against the sent CRC bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr   <= '0;
            r_mis    <= 1'b0;
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_err <= w_last && (r_mis || w_bad);
            if (w_last && (r_mis || w_bad)) r_sticky <= 1'b1;
            if (w_load) begin
                r_lfsr <= '0;
                r_mis  <= 1'b0;
            end else if (w_xfer) begin
                if (r_idx > 5'd8) begin
                    r_lfsr <= {r_lfsr[7:0], 1'b0} ^ (w_bad ? 9'h103 : 9'h000);
                end else begin
                    r_lfsr <= {r_lfsr[7:0], 1'b0};
                    r_mis  <= r_mis || w_bad;
                end
            end
        end
    end
`endif
endmodule

// File: doc/crc_frame_serializer.md
Name: crc_frame_serializer

Overview:
- Downstream stage of the serial CRC-9 encoder (generator 1+y+y^8+y^9).
- Accepts a 10-bit message word plus its 9-bit CRC remainder through a valid/ready handshake.
- Serializes them into a 19-bit codeword, message MSB first then CRC MSB first, with downstream backpressure, frame markers and a frame counter.
- Optional on-the-fly CRC re-computation flags corrupted encoder output.

Parameters:
GAP_CYCLES, 1, idle cycles (ser_valid=0) inserted after each frame; range 0..15
COUNT_W, 8, width of completed-frame counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
data_in  input  10  message word, sampled on load handshake
crc_in  input  9  CRC remainder of data_in, sampled on load handshake
load_valid  input  1  upstream has data_in/crc_in valid
load_ready  output  1  block can accept a word this cycle
ser_ready  input  1  downstream accepts ser_out this cycle
ser_out  output  1  current codeword bit
ser_valid  output  1  ser_out valid
frame_start  output  1  high while bit 18 (first message bit) is presented
frame_end  output  1  high while bit 0 (last CRC bit) is presented
crc_phase  output  1  high while CRC bits (codeword bits 8..0) are presented
frame_count  output  COUNT_W  number of completed frames, wraps modulo 2^COUNT_W

Behaviour:
- Reset (reset_n=0, async): state=IDLE; ser_out=0, ser_valid=0, frame_start=0, frame_end=0, crc_phase=0, frame_count=0, load_ready=1 combinationally from IDLE; shift register and bit index cleared.
- Codeword: cw[18:0] = {data_in, crc_in}; transmitted cw[18] first, cw[0] last.
- States: IDLE, SEND, GAP.
- IDLE: load_ready=1. Handshake on the edge where load_valid&&load_ready -> latch cw, idx=18, go to SEND. ser_valid=1 with cw[18] in the following cycle (1-cycle latency).
- SEND: ser_valid=1, ser_out=cw[idx]. Bit transfers on the edge where ser_valid&&ser_ready; idx decrements. ser_ready=0 holds ser_out, idx and all markers unchanged, indefinitely.
- Transfer of idx=0: frame_count+1. Go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: ser_valid=0, load_ready=0; count GAP_CYCLES cycles, then IDLE.
- Back-to-back (GAP_CYCLES=0 only): load_ready=1 also during idx=0 cycle when ser_ready=1. A simultaneous load handshake latches the new cw, and the next cycle presents its bit 18 with no bubble. load_valid=0 at that point -> IDLE.
- Markers are combinational from registered state: frame_start=(SEND&&idx==18); frame_end=(SEND&&idx==0); crc_phase=(SEND&&idx<=8).
- frame_count: 2^COUNT_W-1 -> 0 on next completed frame, no saturation.
- data_in/crc_in changes outside the handshake edge are ignored.
- Reset mid-frame: partial frame discarded, frame_count not incremented, ser_valid=0 immediately (async).

Optional Feature:
CRC_SELFCHECK_EN defined:
- Adds a serial 9-bit LFSR (init 0, feedback taps per 1+y+y^8+y^9) advancing on each transferred message bit; during CRC bits it compares the remainder MSB-first against transmitted bits.
- Output crc_err (1 bit, reset 0): pulses high for exactly one cycle, the cycle after the idx=0 transfer, if any CRC bit mismatched.
- Output crc_err_sticky (1 bit, reset 0): sets with crc_err, cleared only by reset.
- LFSR cleared at each load handshake.
Not defined: no LFSR, crc_err/crc_err_sticky ports absent, no area cost.

Test Plan:
- Reset then load data_in=10'h200, crc_in=9'h004, ser_ready=1 -> ser_out = 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0 on 19 consecutive cycles starting 1 cycle after handshake; frame_start on first, crc_phase on last 9, frame_end on last; frame_count=1; ser_valid low for 1 GAP cycle.
- data_in=10'h001, crc_in=9'h103, ser_ready toggled 1,0,0,1 pattern -> same 19 bits {0000000001,100000011} delivered only on ready cycles, ser_out stable during stalls.
- GAP_CYCLES=0, load_valid held high with 3 words -> 57 contiguous ser_valid cycles, load_ready pulsing on each idx=0 cycle, frame_count=3.
- reset_n asserted at bit 7 of a frame -> ser_valid=0 same cycle, frame_count unchanged, next load restarts at bit 18.
- COUNT_W=2, send 5 frames -> frame_count 1,2,3,0,1.
- CRC_SELFCHECK_EN: data_in=10'h200 with crc_in=9'h004 -> crc_err stays 0; crc_in=9'h005 -> one-cycle crc_err after frame end, crc_err_sticky=1 until reset.
